// File: rtl/ex_mem_buffer.sv
// Two-entry registered skid buffer between the EX-stage ALU and the MEM stage.
// Also flags, stickily, any accepted entry whose zero flag disagrees with its result.
module ex_mem_buffer #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_z,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_reg_write,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_z,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_store_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_reg_write,
    output logic [1:0]        count,
    output logic              zero_err
);

    typedef struct packed {
        logic [DATA_W-1:0] z;
        logic              zero;
        logic [DATA_W-1:0] store_data;
        logic [RD_W-1:0]   rd;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
    } entry_t;

    entry_t      slot [2];
    entry_t      in_entry;
    logic        head;
    logic [1:0]  count_q;
    logic        zero_err_q;
    logic        push;
    logic        pop;
    logic        wr_idx;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign wr_idx    = head ^ count_q[0];

    always_comb begin
        in_entry            = '0;
        in_entry.z          = in_z;
        in_entry.zero       = in_zero;
        in_entry.store_data = in_store_data;
        in_entry.rd         = in_rd;
        in_entry.mem_read   = in_mem_read;
        in_entry.mem_write  = in_mem_write;
        in_entry.reg_write  = in_reg_write;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot[0]    <= '0;
            slot[1]    <= '0;
            head       <= 1'b0;
            count_q    <= 2'd0;
            zero_err_q <= 1'b0;
        end else if (flush) begin
            // Flushed pushes are neither stored nor zero-checked.
            head    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_idx] <= in_entry;
                if (in_zero != ~|in_z) begin
                    zero_err_q <= 1'b1;
                end
            end
            if (pop) begin
                head <= ~head;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign out_z          = slot[head].z;
    assign out_zero       = slot[head].zero;
    assign out_store_data = slot[head].store_data;
    assign out_rd         = slot[head].rd;
    assign out_mem_read   = slot[head].mem_read;
    assign out_mem_write  = slot[head].mem_write;
    assign out_reg_write  = slot[head].reg_write;
    assign count          = count_q;
    assign zero_err       = zero_err_q;

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Directed bench for ex_mem_buffer: reset, latency, stall/ordering, streaming,
// flush, sticky zero_err and mid-transfer reset.
module tb_ex_mem_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_z;
    logic        in_zero;
    logic [63:0] in_store_data;
    logic [4:0]  in_rd;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        in_reg_write;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_z;
    logic        out_zero;
    logic [63:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_reg_write;
    logic [1:0]  count;
    logic        zero_err;

    int checks = 0;
    int errors = 0;

    ex_mem_buffer #(.DATA_W(64), .RD_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_z(in_z), .in_zero(in_zero), .in_store_data(in_store_data),
        .in_rd(in_rd), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_reg_write(in_reg_write), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_zero(out_zero), .out_store_data(out_store_data),
        .out_rd(out_rd), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_reg_write(out_reg_write), .count(count), .zero_err(zero_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] z, input logic zf,
                         input logic [4:0] rd, input logic mr, input logic mw,
                         input logic rw);
        in_valid      = v;
        in_z          = z;
        in_zero       = zf;
        in_store_data = z ^ 64'hA5A5_0000_0000_5A5A;
        in_rd         = rd;
        in_mem_read   = mr;
        in_mem_write  = mw;
        in_reg_write  = rw;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_zero_err", 64'(zero_err), 64'd0);
        chk("rst_out_z", out_z, 64'd0);

        // Single entry latency
        out_ready = 1'b1;
        drive(1'b1, 64'h5, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lat_out_valid", 64'(out_valid), 64'd1);
        chk("lat_out_z", out_z, 64'h5);
        chk("lat_out_rd", 64'(out_rd), 64'd3);
        chk("lat_out_reg_write", 64'(out_reg_write), 64'd1);
        chk("lat_store_data", out_store_data, 64'h5 ^ 64'hA5A5_0000_0000_5A5A);
        chk("lat_count", 64'(count), 64'd1);
        tick();
        chk("lat_count_drain", 64'(count), 64'd0);
        chk("lat_valid_drain", 64'(out_valid), 64'd0);

        // Stall, full refusal, ordering and head wrap
        out_ready = 1'b0;
        drive(1'b1, 64'd10, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 64'd20, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 64'd30, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1);
        chk("full_count", 64'(count), 64'd2);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_z", out_z, 64'd10);
        tick();
        chk("stall_count", 64'(count), 64'd2);
        chk("stall_out_z", out_z, 64'd10);
        chk("stall_out_rd", 64'(out_rd), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("drain1_out_z", out_z, 64'd20);
        chk("drain1_count", 64'(count), 64'd1);
        tick();
        drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("drain2_out_z", out_z, 64'd30);
        chk("drain2_out_rd", 64'(out_rd), 64'd4);
        chk("drain2_count", 64'(count), 64'd1);
        tick();
        chk("drain3_count", 64'(count), 64'd0);

        // Streaming: one entry per cycle, count stays 1
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 64'(i), 1'b0, 5'(i), 1'b0, 1'b0, 1'b1);
            tick();
            chk("stream_out_z", out_z, 64'(i));
            chk("stream_count", 64'(count), 64'd1);
        end
        drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("stream_end_count", 64'(count), 64'd0);

        // Flush with a full buffer and a same-cycle (bad zero flag) push
        out_ready = 1'b0;
        drive(1'b1, 64'd40, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 64'd50, 1'b0, 5'd6, 1'b0, 1'b0, 1'b1);
        tick();
        chk("pre_flush_count", 64'(count), 64'd2);
        flush = 1'b1;
        drive(1'b1, 64'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_no_zero_check", 64'(zero_err), 64'd0);
        out_ready = 1'b1;
        drive(1'b1, 64'd70, 1'b0, 5'd8, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("post_flush_out_z", out_z, 64'd70);
        chk("post_flush_count", 64'(count), 64'd1);
        tick();
        chk("post_flush_drain", 64'(count), 64'd0);

        // Sticky zero_err; both mem bits passed through verbatim
        drive(1'b1, 64'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("zerr_set", 64'(zero_err), 64'd1);
        chk("ctl_mem_read", 64'(out_mem_read), 64'd1);
        chk("ctl_mem_write", 64'(out_mem_write), 64'd1);
        chk("ctl_reg_write", 64'(out_reg_write), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("zerr_after_flush", 64'(zero_err), 64'd1);
        drive(1'b1, 64'd0, 1'b1, 5'd10, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("zerr_after_good", 64'(zero_err), 64'd1);
        chk("good_out_zero", 64'(out_zero), 64'd1);
        tick();

        // Reset with a full, stalled buffer
        out_ready = 1'b0;
        drive(1'b1, 64'd80, 1'b0, 5'd11, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 64'd90, 1'b0, 5'd12, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_count", 64'(count), 64'd2);
        chk("pre_rst_out_z", out_z, 64'd80);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_z", out_z, 64'd0);
        chk("mid_rst_out_rd", 64'(out_rd), 64'd0);
        chk("mid_rst_zero_err", 64'(zero_err), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_buffer.md
Name: ex_mem_buffer

Overview:
- Two-entry registered skid buffer between the 64-bit ALU (EX stage) and the data-memory stage (MEM).
- Captures the ALU result, zero flag, store data, destination register and memory/writeback control bits under a valid/ready handshake.
- Decouples a stalling memory stage from the ALU.
- Independently checks that the incoming zero flag matches the incoming result; a mismatch sets a sticky error flag.

Parameters:
- DATA_W, 64, width of ALU result and store data
- RD_W, 5, destination register index width

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  EX presents a valid result this cycle
- in_ready  out  1  buffer accepts an entry this cycle
- in_z  in  DATA_W  ALU result
- in_zero  in  1  ALU zero flag
- in_store_data  in  DATA_W  register-b value for stores
- in_rd  in  RD_W  destination register
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- in_reg_write  in  1  writeback enable
- flush  in  1  discard all held entries (branch mispredict)
- out_valid  out  1  head entry valid
- out_ready  in  1  MEM consumes head this cycle
- out_z  out  DATA_W  head result
- out_zero  out  1  head zero flag
- out_store_data  out  DATA_W  head store data
- out_rd  out  RD_W  head destination
- out_mem_read, out_mem_write, out_reg_write  out  1 each  head control bits
- count  out  2  occupancy, 0..2
- zero_err  out  1  sticky: an accepted entry had in_zero != (in_z == 0)

Behaviour:
- Clock and reset: one clock, clk; synchronous active-low reset, reset_n. All state changes on the rising edge of clk.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Storage and outputs:
  - Storage is two entry slots, with a head pointer and a 2-bit count.
  - All out_* signals come directly from the head slot register; there is no combinational path from in_* to out_*.
  - in_ready = (count != 2), derived from registered count only, with no dependence on out_ready. A full buffer therefore refuses a push even in a cycle that pops.
  - out_valid = (count != 0).
- Count update:
  - count += push - pop.
  - Push writes slot (head + count) mod 2.
  - Pop advances head modulo 2 (wrap-around).
- Latency: an entry pushed into an empty buffer appears on out_* with out_valid=1 one cycle later. Throughput is 1 entry/cycle while out_ready stays high.
- Simultaneous push and pop:
  - count=1: count stays 1, head advances, and the new entry becomes head next cycle.
  - count=0: pop is impossible (out_valid=0), so the entry is written and count becomes 1.
- Data stability: when out_valid=1 and out_ready=0, all out_* hold stable until popped.
- Ignored inputs: in_* values are ignored when push=0.
- Flush:
  - Next cycle, count=0 and head=0.
  - Any same-cycle push is discarded.
  - zero_err is not cleared.
  - Slot contents may remain but are invalid.
- Zero check and zero_err:
  - On each push, compare in_zero against the reduction NOR of in_z. On mismatch, zero_err becomes 1 next cycle and stays 1.
  - zero_err is cleared only by reset.
  - A push discarded by flush is not checked.
- Reset (reset_n=0 at a clock edge):
  - count=0, head=0, out_valid=0, zero_err=0.
  - out_z, out_store_data and out_rd = 0; out_zero and the three control outputs = 0.
  - Reset overrides flush and push.
  - Reset mid-transfer drops all held entries.
  - in_ready = 1 from the first cycle after reset.
- Control-bit rule: control bits are carried verbatim; no decoding. mem_read and mem_write both set is passed through unchanged.

Test Plan:
- Reset, then push in_z=64'h5, in_zero=0, rd=3, reg_write=1 with out_ready=1 -> next cycle out_valid=1, out_z=5, out_rd=3, out_reg_write=1, count=1; following cycle count=0.
- out_ready=0; push in_z=10 then in_z=20 on consecutive cycles; hold in_valid with in_z=30 -> count=2, in_ready=0, out_z=10 stable, 30 not accepted. Raise out_ready -> outputs 10, then 20, then 30 once accepted. Verifies ordering and head wrap.
- Steady streaming 1..8 with in_valid=1, out_ready=1 every cycle -> out_z sequence 1..8 one cycle delayed, count constant 1, no bubbles.
- count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, in_ready=1; no flushed or same-cycle value appears later.
- Push in_z=0 with in_zero=0 -> zero_err=1 next cycle. It stays 1 after flush and after further correct pushes (in_z=0, in_zero=1), and clears only on reset_n=0.
- Assert reset_n=0 for one cycle with count=2 and out_ready=0 -> next cycle count=0, out_valid=0, out_z=0, zero_err=0, in_ready=1.
